// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_MARK = 2'b10;
  localparam logic [1:0] PAR_ODD  = 2'b11;

  localparam int unsigned DATA_BITS = 8;

  // Parity bit a transmitter would send for this byte and parity type.
  function automatic logic parity_bit(input logic [1:0] ptype, input logic [DATA_BITS-1:0] data);
    logic p;
    case (ptype)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the async rx line plus falling-edge detect on the synced value.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit, mid-bit sampling at clk rate.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_divisor,
  input  logic [1:0]       i_parity_type,
  input  logic             i_fifo_full,
  output logic             o_fifo_wr_en,
  output logic [7:0]       o_rx_data,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_overrun_err,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS);

  logic rx_s, rx_fall;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  uart_state_e          state_q, state_d;
  logic [DIV_W-1:0]     timer_q, timer_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [1:0]           ptype_q, ptype_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 busy_q, busy_d;

  logic [DIV_W-1:0] half_m1_c;
  logic             bit_end_c;

  assign half_m1_c = (div_q >> 1) - DIV_W'(1);
  assign bit_end_c = (timer_q == div_q - DIV_W'(1));

  // Next-state, bit timing and completion outputs.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    div_d     = div_q;
    ptype_d   = ptype_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    rx_data_d = rx_data_q;
    wr_en_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (rx_fall) begin
          state_d = START;
          div_d   = baud_divisor;
          ptype_d = i_parity_type;
        end
      end
      START: begin
        if (timer_q == half_m1_c) begin
          timer_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          timer_d   = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = (ptype_q == PAR_NONE) ? STOP : PARITY;
          end
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          timer_d = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          // Frame done mid stop bit; back to IDLE so the next start edge is caught.
          timer_d   = '0;
          state_d   = IDLE;
          rx_data_d = shift_q;
          ferr_d    = ~rx_s;
          perr_d    = (ptype_q != PAR_NONE) && (par_q != parity_bit(ptype_q, shift_q));
          if (i_fifo_full) begin
            oerr_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      div_q     <= '0;
      ptype_q   <= PAR_NONE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      rx_data_q <= '0;
      wr_en_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      ptype_q   <= ptype_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      rx_data_q <= rx_data_d;
      wr_en_q   <= wr_en_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
      busy_q    <= busy_d;
    end
  end

  assign o_fifo_wr_en  = wr_en_q;
  assign o_rx_data     = rx_data_q;
  assign o_parity_err  = perr_q;
  assign o_frame_err   = ferr_q;
  assign o_overrun_err = oerr_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected completions queued and
// compared when the receiver strobes.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DW-1:0] div = DW'(16);
  logic [1:0]    ptype = PAR_NONE;
  logic          fifo_full = 1'b0;
  logic          o_fifo_wr_en, o_parity_err, o_frame_err, o_overrun_err, o_busy;
  logic [7:0]    o_rx_data;

  uart_rx #(.SYNC_STAGES(SYNC), .DIV_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .baud_divisor  (div),
    .i_parity_type (ptype),
    .i_fifo_full   (fifo_full),
    .o_fifo_wr_en  (o_fifo_wr_en),
    .o_rx_data     (o_rx_data),
    .o_parity_err  (o_parity_err),
    .o_frame_err   (o_frame_err),
    .o_overrun_err (o_overrun_err),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       wr;
    logic       perr;
    logic       ferr;
    logic       oerr;
    int         start;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Any strobe pops one expected completion; strobes with nothing queued are spurious.
  always @(negedge clk) begin
    if (rst_n && (o_fifo_wr_en || o_overrun_err || o_parity_err || o_frame_err)) begin
      if (sb.size() == 0) begin
        check("spurious_strobe",
              {28'd0, o_fifo_wr_en, o_overrun_err, o_parity_err, o_frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_en",   32'(o_fifo_wr_en),  32'(e.wr));
        check("rx_data", 32'(o_rx_data),     32'(e.data));
        check("par_err", 32'(o_parity_err),  32'(e.perr));
        check("frm_err", 32'(o_frame_err),   32'(e.ferr));
        check("ovr_err", 32'(o_overrun_err), 32'(e.oerr));
        check("latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  task automatic drive_bit(input logic b, input int d);
    rx = b;
    repeat (d) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] data, input int d, input logic [1:0] pt,
                            input bit flip_par, input logic stop_v);
    exp_t e;
    logic pbit;
    div   = DW'(d);
    ptype = pt;
    case (pt)
      PAR_EVEN: pbit = ^data;
      PAR_ODD:  pbit = ~^data;
      default:  pbit = 1'b1;
    endcase
    pbit   = pbit ^ flip_par;
    e.data = data;
    e.wr   = ~fifo_full;
    e.oerr = fifo_full;
    e.perr = (pt != PAR_NONE) && flip_par;
    e.ferr = ~stop_v;
    e.start = cyc;
    e.lat  = SYNC + d / 2 + ((pt == PAR_NONE) ? 9 : 10) * d + 1;
    sb.push_back(e);
    drive_bit(1'b0, d);
    for (int i = 0; i < 8; i++) drive_bit(data[i], d);
    if (pt != PAR_NONE) drive_bit(pbit, d);
    drive_bit(stop_v, d);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("rst_data",  32'(o_rx_data),    32'd0);
    check("rst_perr",  32'(o_parity_err), 32'd0);
    check("rst_ferr",  32'(o_frame_err),  32'd0);
    check("rst_oerr",  32'(o_overrun_err), 32'd0);
    check("rst_busy",  32'(o_busy),       32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send_frame(8'hA5, 16, PAR_NONE, 1'b0, 1'b1);
    wait_drain("drain_a5");

    send_frame(8'h3C, 16, PAR_EVEN, 1'b0, 1'b1);
    wait_drain("drain_even_ok");
    send_frame(8'h3C, 16, PAR_EVEN, 1'b1, 1'b1);
    wait_drain("drain_even_bad");
    send_frame(8'h3C, 16, PAR_ODD, 1'b0, 1'b1);
    wait_drain("drain_odd_ok");
    send_frame(8'h3C, 16, PAR_ODD, 1'b1, 1'b1);
    wait_drain("drain_odd_bad");
    send_frame(8'h3C, 16, PAR_MARK, 1'b0, 1'b1);
    wait_drain("drain_mark_ok");
    send_frame(8'h3C, 16, PAR_MARK, 1'b1, 1'b1);
    wait_drain("drain_mark_bad");

    // Bad stop bit, then the line stays low for three more frame times.
    send_frame(8'h55, 16, PAR_NONE, 1'b0, 1'b0);
    repeat (3 * 10 * 16) @(posedge clk);
    #1;
    check("break_sb_empty", 32'(sb.size()), 32'd0);
    check("break_busy", 32'(o_busy), 32'd0);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    // Short low glitch: receiver enters START then abandons it.
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_busy_hi", 32'(o_busy), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_busy_lo", 32'(o_busy), 32'd0);
    check("glitch_data_held", 32'(o_rx_data), 32'h55);

    // Reset in the middle of the data bits.
    div   = DW'(16);
    ptype = PAR_NONE;
    rx    = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_data", 32'(o_rx_data), 32'd0);
    check("mid_rst_wr", 32'(o_fifo_wr_en), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h81, 16, PAR_NONE, 1'b0, 1'b1);
    wait_drain("drain_81");

    fifo_full = 1'b1;
    send_frame(8'h5A, 16, PAR_NONE, 1'b0, 1'b1);
    wait_drain("drain_ovr");
    fifo_full = 1'b0;

    send_frame(8'h00, 4, PAR_NONE, 1'b0, 1'b1);
    send_frame(8'hFF, 4, PAR_NONE, 1'b0, 1'b1);
    rx = 1'b1;
    wait_drain("drain_b2b");
    check("end_busy", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
